// File: rtl/wb_unified_mem_arb.sv
`timescale 1ns/1ps
// Two-master Wishbone front end sharing one single-port synchronous SRAM.
// Also hosts a tohost mailbox word with a one-cycle strobe when it becomes nonzero.
module wb_unified_mem_arb #(
    parameter int ADDR_W       = 13,
    parameter int TOHOST_WADDR = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       iwb_adr_i,
    input  logic              iwb_cyc_i,
    input  logic              iwb_stb_i,
    output logic [31:0]       iwb_dat_o,
    output logic              iwb_ack_o,
    input  logic [31:0]       dwb_adr_i,
    input  logic [31:0]       dwb_dat_i,
    input  logic              dwb_we_i,
    input  logic [3:0]        dwb_sel_i,
    input  logic              dwb_cyc_i,
    input  logic              dwb_stb_i,
    output logic [31:0]       dwb_dat_o,
    output logic              dwb_ack_o,
    output logic              dwb_err_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       tohost_o,
    output logic              tohost_valid_o
);

    localparam logic [31:0]       NOP_INSN = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] TOHOST_W = TOHOST_WADDR[ADDR_W-1:0];

    typedef enum logic [1:0] {IDLE, ACK_I, ACK_D, ERR_D} state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 0 = instruction, 1 = data
    logic        i_oob_q, i_oob_d;
    logic [31:0] tohost_q, tohost_d;
    logic        tohost_valid_q, tohost_valid_d;

    logic              i_req, d_req, grant_i, grant_d, i_oob, d_oob;
    logic              en_c;
    logic [3:0]        we_c;
    logic [ADDR_W-1:0] addr_c;
    logic [31:0]       tohost_merge;
    logic              unused_adr_lsbs;

    assign unused_adr_lsbs = ^{iwb_adr_i[1:0], dwb_adr_i[1:0]};

    assign i_req   = iwb_cyc_i & iwb_stb_i;
    assign d_req   = dwb_cyc_i & dwb_stb_i;
    // On a tie the master that did not win last time gets the slot.
    assign grant_d = d_req & (~i_req | ~last_grant_q);
    assign grant_i = i_req & ~grant_d;
    assign i_oob   = |iwb_adr_i[31:ADDR_W+2];
    assign d_oob   = |dwb_adr_i[31:ADDR_W+2];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign tohost_merge[8*gi +: 8] = dwb_sel_i[gi] ? dwb_dat_i[8*gi +: 8]
                                                       : tohost_q[8*gi +: 8];
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        i_oob_d        = i_oob_q;
        tohost_d       = tohost_q;
        tohost_valid_d = 1'b0;
        en_c           = 1'b0;
        we_c           = 4'b0000;
        addr_c         = '0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    last_grant_d = 1'b1;
                    addr_c       = dwb_adr_i[ADDR_W+1:2];
                    state_d      = d_oob ? ERR_D : ACK_D;
                    if (!d_oob) begin
                        en_c = 1'b1;
                        we_c = dwb_we_i ? dwb_sel_i : 4'b0000;
                        if (dwb_we_i && addr_c == TOHOST_W) begin
                            tohost_d       = tohost_merge;
                            tohost_valid_d = |tohost_merge;
                        end
                    end
                end else if (grant_i) begin
                    last_grant_d = 1'b0;
                    addr_c       = iwb_adr_i[ADDR_W+1:2];
                    en_c         = ~i_oob;
                    i_oob_d      = i_oob;
                    state_d      = ACK_I;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b0;
            i_oob_q        <= 1'b0;
            tohost_q       <= '0;
            tohost_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            i_oob_q        <= i_oob_d;
            tohost_q       <= tohost_d;
            tohost_valid_q <= tohost_valid_d;
        end
    end

    // SRAM strobes are gated by reset so nothing is written while rst_n is low.
    assign mem_en_o    = en_c & rst_n;
    assign mem_we_o    = we_c & {4{rst_n}};
    assign mem_addr_o  = addr_c;
    assign mem_wdata_o = dwb_dat_i;

    // Responses are qualified by cyc so an abandoned cycle is never acked.
    assign iwb_ack_o = (state_q == ACK_I) & iwb_cyc_i;
    assign iwb_dat_o = (state_q == ACK_I) ? (i_oob_q ? NOP_INSN : mem_rdata_i) : '0;
    assign dwb_ack_o = (state_q == ACK_D) & dwb_cyc_i;
    assign dwb_err_o = (state_q == ERR_D) & dwb_cyc_i;
    assign dwb_dat_o = (state_q == ACK_D) ? mem_rdata_i : '0;

    assign tohost_o       = tohost_q;
    assign tohost_valid_o = tohost_valid_q;

endmodule

// File: tb/tb_wb_unified_mem_arb.sv
`timescale 1ns/1ps
// Randomized bench for wb_unified_mem_arb: SRAM behavioural model plus a
// transaction-level reference of memory contents, mailbox and arbitration order.
module tb_wb_unified_mem_arb;

    localparam int ADDR_W       = 13;
    localparam int TOHOST_WADDR = 1024;
    localparam int DEPTH        = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       iwb_adr_i, iwb_dat_o;
    logic              iwb_cyc_i, iwb_stb_i, iwb_ack_o;
    logic [31:0]       dwb_adr_i, dwb_dat_i, dwb_dat_o;
    logic              dwb_we_i, dwb_cyc_i, dwb_stb_i, dwb_ack_o, dwb_err_o;
    logic [3:0]        dwb_sel_i;
    logic              mem_en_o;
    logic [3:0]        mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o, mem_rdata_i;
    logic [31:0]       tohost_o;
    logic              tohost_valid_o;

    always #5 clk = ~clk;

    wb_unified_mem_arb #(.ADDR_W(ADDR_W), .TOHOST_WADDR(TOHOST_WADDR)) dut (
        .clk(clk), .rst_n(rst_n),
        .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
        .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
        .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_we_i(dwb_we_i),
        .dwb_sel_i(dwb_sel_i), .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i),
        .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .tohost_o(tohost_o), .tohost_valid_o(tohost_valid_o)
    );

    // Physical SRAM seen by the DUT: byte-write, one-cycle read latency.
    logic [31:0] sram [DEPTH];
    always @(posedge clk) begin
        if (mem_en_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            mem_rdata_i <= sram[mem_addr_o];
        end
    end

    // Reference state, updated once per completed transaction.
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_tohost;
    bit          exp_last;   // 1 = data master won the last grant
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", tag, got, exp);
        end
    endtask

    task automatic clear_bus();
        iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0; iwb_adr_i = '0;
        dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; dwb_adr_i = '0;
        dwb_we_i  = 1'b0; dwb_sel_i = '0;   dwb_dat_i = '0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        return r;
    endfunction

    // One single-master transaction; called and returns at posedge+1.
    task automatic xact(input bit m, input logic [31:0] adr, input bit we,
                        input logic [3:0] sel, input logic [31:0] dat, input string tag);
        bit          oob;
        int          word;
        logic [31:0] exp_dat;
        bit          exp_tv;
        oob     = (adr >> (ADDR_W + 2)) != 0;
        word    = int'((adr >> 2) % DEPTH);
        exp_dat = 32'h0000_0013;
        exp_tv  = 1'b0;
        if (!oob) exp_dat = ref_mem[word];
        if (m && we && !oob) begin
            ref_mem[word] = merge(ref_mem[word], dat, sel);
            if (word == TOHOST_WADDR) begin
                exp_tohost = merge(exp_tohost, dat, sel);
                exp_tv     = exp_tohost != 0;
            end
        end
        exp_last = m;

        if (m) begin
            dwb_adr_i = adr; dwb_we_i = we; dwb_sel_i = sel; dwb_dat_i = dat;
            dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
        end else begin
            iwb_adr_i = adr; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
        end
        #1;
        check_eq({tag, "/en"}, 32'(mem_en_o), 32'(!oob));
        if (!oob) check_eq({tag, "/addr"}, 32'(mem_addr_o), 32'(word));
        if (m && !oob) check_eq({tag, "/we"}, 32'(mem_we_o), 32'(we ? sel : 4'h0));
        @(posedge clk); #1;
        check_eq({tag, "/iack"}, 32'(iwb_ack_o), 32'(!m));
        check_eq({tag, "/dack"}, 32'(dwb_ack_o), 32'(m && !oob));
        check_eq({tag, "/derr"}, 32'(dwb_err_o), 32'(m && oob));
        if (!m) check_eq({tag, "/idat"}, iwb_dat_o, exp_dat);
        if (m && !we && !oob) check_eq({tag, "/ddat"}, dwb_dat_o, exp_dat);
        check_eq({tag, "/tohost"}, tohost_o, exp_tohost);
        check_eq({tag, "/tvalid"}, 32'(tohost_valid_o), 32'(exp_tv));
        $display("xact %s m=%0d adr=%08h we=%0d sel=%h dat=%08h", tag, m, adr, we, sel, dat);
        clear_bus();
        @(posedge clk); #1;
        check_eq({tag, "/clear"}, 32'({iwb_ack_o, dwb_ack_o, dwb_err_o, tohost_valid_o}), 32'h0);
    endtask

    // Both masters raise a read in the same cycle; winner follows last-grant rule.
    task automatic tie_round(input string tag);
        bit win_d;
        int iw, dw;
        win_d = !exp_last;
        iw = int'($urandom % 32);
        dw = int'($urandom % 32);
        iwb_adr_i = 32'(iw << 2); iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
        dwb_adr_i = 32'(dw << 2); dwb_we_i = 1'b0; dwb_sel_i = 4'hF;
        dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
        #1;
        check_eq({tag, "/win_addr"}, 32'(mem_addr_o), 32'(win_d ? dw : iw));
        @(posedge clk); #1;
        check_eq({tag, "/win_ack"}, 32'({iwb_ack_o, dwb_ack_o}), win_d ? 32'b01 : 32'b10);
        check_eq({tag, "/win_dat"}, win_d ? dwb_dat_o : iwb_dat_o, ref_mem[win_d ? dw : iw]);
        if (win_d) begin dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; end
        else       begin iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0; end
        @(posedge clk); #1;
        check_eq({tag, "/lose_addr"}, 32'(mem_addr_o), 32'(win_d ? iw : dw));
        @(posedge clk); #1;
        check_eq({tag, "/lose_ack"}, 32'({iwb_ack_o, dwb_ack_o}), win_d ? 32'b10 : 32'b01);
        check_eq({tag, "/lose_dat"}, win_d ? iwb_dat_o : dwb_dat_o, ref_mem[win_d ? iw : dw]);
        $display("xact %s tie first=%s iw=%0d dw=%0d", tag, win_d ? "data" : "instr", iw, dw);
        exp_last = !win_d;
        clear_bus();
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] adr;
        int          word;
        bit          m, we;

        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        sram[0] = 32'h0050_0093;      ref_mem[0] = sram[0];
        sram[32'h100] = 32'hAABB_CCDD; ref_mem[32'h100] = sram[32'h100];
        exp_tohost = '0;
        exp_last   = 1'b0;

        // Reset with a live data write: nothing may reach the SRAM.
        clear_bus();
        rst_n = 1'b0;
        dwb_adr_i = 32'h8; dwb_we_i = 1'b1; dwb_sel_i = 4'hF; dwb_dat_i = 32'hDEAD_BEEF;
        dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst/mem_en", 32'(mem_en_o), 32'h0);
        check_eq("rst/mem_we", 32'(mem_we_o), 32'h0);
        check_eq("rst/outs", 32'({iwb_ack_o, dwb_ack_o, dwb_err_o, tohost_valid_o}), 32'h0);
        check_eq("rst/tohost", tohost_o, 32'h0);
        check_eq("rst/idat", iwb_dat_o, 32'h0);
        check_eq("rst/ddat", dwb_dat_o, 32'h0);
        clear_bus();
        rst_n = 1'b1;
        @(posedge clk); #1;

        tie_round("tie0");
        tie_round("tie1");
        tie_round("tie2");

        xact(0, 32'h0, 0, 4'h0, 32'h0, "ifetch0");
        xact(1, 32'h400, 1, 4'b0101, 32'h1122_3344, "bytewr");
        xact(1, 32'h400, 0, 4'hF, 32'h0, "byterd");
        check_eq("byterd/literal", ref_mem[32'h100], 32'hAA22_CC44);
        xact(1, 32'h1000, 1, 4'hF, 32'h1, "tohost1");
        xact(1, 32'h1000, 1, 4'hF, 32'h0, "tohost0");
        xact(1, 32'h0001_0000, 0, 4'hF, 32'h0, "derr");
        xact(0, 32'h0001_0000, 0, 4'h0, 32'h0, "inop");
        xact(1, 32'h13, 1, 4'h0, 32'hFFFF_FFFF, "sel0");
        xact(1, 32'h10, 0, 4'h0, 32'h0, "sel0rd");

        for (int t = 0; t < 150; t++) begin
            m  = $urandom % 2;
            we = $urandom % 2;
            case ($urandom % 8)
                5:       word = TOHOST_WADDR;
                6:       word = -1;
                7:       word = int'($urandom % DEPTH);
                default: word = int'($urandom % 32);
            endcase
            if (word < 0) adr = $urandom | (32'h1 << $urandom_range(ADDR_W + 2, 31));
            else          adr = 32'(word << 2) | ($urandom % 4);
            xact(m, adr, m && we, 4'($urandom), $urandom, $sformatf("rnd%0d", t));
        end

        // Master abandons its cycle before the ack cycle.
        dwb_adr_i = 32'h8; dwb_we_i = 1'b0; dwb_sel_i = 4'hF; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
        @(posedge clk); #1;
        clear_bus();
        #1;
        check_eq("abort/dack", 32'(dwb_ack_o), 32'h0);
        @(posedge clk); #1;
        exp_last = 1'b1;
        xact(0, 32'h4, 0, 4'h0, 32'h0, "abort/next");

        // Reset lands in the ack cycle of a data read.
        dwb_adr_i = 32'hC; dwb_we_i = 1'b0; dwb_sel_i = 4'hF; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst/dack", 32'(dwb_ack_o), 32'h0);
        check_eq("midrst/ddat", dwb_dat_o, 32'h0);
        clear_bus();
        exp_tohost = '0;
        exp_last   = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_eq("midrst/post", 32'({iwb_ack_o, dwb_ack_o, dwb_err_o}), 32'h0);
        end
        check_eq("midrst/tohost", tohost_o, exp_tohost);
        tie_round("tie_postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
